// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: ID/EX hazard inputs and pipeline control outputs of the stall controller
interface hazard_stall_ctrl_if;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic        id_mdu_start;
    logic        id_mdu_is_div;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic        ex_branch_taken;
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        mdu_busy;
    logic        mdu_done;
    logic [15:0] stall_count;
    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_mdu_start, id_mdu_is_div,
               ex_rd, ex_mem_read, ex_branch_taken,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush, mdu_busy, mdu_done, stall_count
    );
    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_mdu_start, id_mdu_is_div,
               ex_rd, ex_mem_read, ex_branch_taken,
        output pc_write, if_id_write, if_id_flush, id_ex_flush, mdu_busy, mdu_done, stall_count
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use/branch hazard control and multi-cycle MDU sequencing for the 5-stage core
module hazard_stall_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input logic clk,
    input logic rst,
    hazard_stall_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [15:0]      stall_q;
    logic             lu;
    assign lu = bus.ex_mem_read && bus.ex_rd != 5'd0 &&
                ((bus.id_uses_rs1 && bus.id_rs1 == bus.ex_rd) ||
                 (bus.id_uses_rs2 && bus.id_rs2 == bus.ex_rd));
    assign bus.stall_count = stall_q;
    assign bus.mdu_busy    = !rst && state == BUSY;
    assign bus.mdu_done    = !rst && state == DONE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            stall_q <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            stall_q <= (!bus.pc_write && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
        end
    end
    // a redirect wins over everything, including an in-flight MDU op which is abandoned
    always_comb begin
        state_n         = state;
        cnt_n           = cnt;
        bus.pc_write    = 1'b1;
        bus.if_id_write = 1'b1;
        bus.if_id_flush = 1'b0;
        bus.id_ex_flush = 1'b0;
        if (rst) begin
            bus.pc_write    = 1'b0;
            bus.if_id_write = 1'b0;
            bus.if_id_flush = 1'b1;
            bus.id_ex_flush = 1'b1;
        end else if (bus.ex_branch_taken) begin
            bus.if_id_flush = 1'b1;
            bus.id_ex_flush = 1'b1;
            state_n         = IDLE;
            cnt_n           = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (lu || bus.id_mdu_start) begin
                        bus.pc_write    = 1'b0;
                        bus.if_id_write = 1'b0;
                        bus.id_ex_flush = 1'b1;
                    end
                    if (!lu && bus.id_mdu_start) begin
                        state_n = BUSY;
                        cnt_n   = bus.id_mdu_is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
                    end
                end
                BUSY: begin
                    bus.pc_write    = 1'b0;
                    bus.if_id_write = 1'b0;
                    bus.id_ex_flush = 1'b1;
                    cnt_n           = cnt - CNT_W'(1);
                    state_n         = cnt == '0 ? DONE : BUSY;
                end
                default: state_n = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed and random checks of the stall controller against a cycle-level model
module tb_hazard_stall_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    hazard_stall_ctrl_if bus();
    hazard_stall_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    // model: an op is remembered by its length and how many cycles have passed since its start cycle
    int op_len = 0;
    int op_age = 0;
    int m_sc = 0;
    always @(negedge clk) begin
        logic lu, busy_now, done_now;
        logic e_pcw, e_ifw, e_iff, e_idf, e_busy, e_done;
        lu = bus.ex_mem_read && bus.ex_rd != 0 &&
             ((bus.id_uses_rs1 && bus.id_rs1 == bus.ex_rd) || (bus.id_uses_rs2 && bus.id_rs2 == bus.ex_rd));
        busy_now = op_len != 0 && op_age <= op_len;
        done_now = op_len != 0 && op_age == op_len + 1;
        {e_pcw, e_ifw, e_iff, e_idf} = 4'b1100;
        e_busy = !rst && busy_now;
        e_done = !rst && done_now;
        if (rst) begin
            {e_pcw, e_ifw, e_iff, e_idf} = 4'b0011;
        end else if (bus.ex_branch_taken) begin
            {e_pcw, e_ifw, e_iff, e_idf} = 4'b1111;
        end else if (busy_now || (!done_now && (lu || bus.id_mdu_start))) begin
            {e_pcw, e_ifw, e_iff, e_idf} = 4'b0001;
        end
        chk("pc_write", bus.pc_write, e_pcw);
        chk("if_id_write", bus.if_id_write, e_ifw);
        chk("if_id_flush", bus.if_id_flush, e_iff);
        chk("id_ex_flush", bus.id_ex_flush, e_idf);
        chk("mdu_busy", bus.mdu_busy, e_busy);
        chk("mdu_done", bus.mdu_done, e_done);
        chk("stall_count", bus.stall_count, m_sc);
        if (rst || bus.ex_branch_taken || done_now) op_len = 0;
        else if (busy_now) op_age++;
        else if (!lu && bus.id_mdu_start) begin
            op_len = bus.id_mdu_is_div ? 32 : 4;
            op_age = 1;
        end
        m_sc = rst ? 0 : (!e_pcw && m_sc < 65535) ? m_sc + 1 : m_sc;
    end
    task automatic clear_in();
        bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_uses_rs1 = 0; bus.id_uses_rs2 = 0;
        bus.id_mdu_start = 0; bus.id_mdu_is_div = 0; bus.ex_rd = 0;
        bus.ex_mem_read = 0; bus.ex_branch_taken = 0;
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        clear_in();
        step();
        step();
        rst = 1'b0;
    endtask
    initial begin
        int nb, done_at, sc_done;
        clear_in();
        do_reset();
        #1;
        chk("t1 sc start", bus.stall_count, 0);
        bus.ex_mem_read = 1; bus.ex_rd = 5; bus.id_rs2 = 5; bus.id_uses_rs2 = 1;
        #1;
        chk("t1 pc_write", bus.pc_write, 0);
        chk("t1 id_ex_flush", bus.id_ex_flush, 1);
        step();
        clear_in();
        #1;
        chk("t1 sc after", bus.stall_count, 1);
        chk("t1 released", bus.pc_write, 1);
        bus.ex_mem_read = 1; bus.ex_rd = 0; bus.id_rs1 = 0; bus.id_rs2 = 0;
        bus.id_uses_rs1 = 1; bus.id_uses_rs2 = 1;
        #1;
        chk("t2 x0 no stall", bus.pc_write, 1);
        step();
        clear_in();
        do_reset();
        bus.id_mdu_start = 1; bus.id_mdu_is_div = 1;
        #1;
        nb = 0; done_at = 0; sc_done = 0;
        for (int c = 1; c <= 40; c++) begin
            if (bus.mdu_busy) nb++;
            if (bus.mdu_done && done_at == 0) begin
                done_at = c;
                sc_done = bus.stall_count;
            end
            step();
            clear_in();
            #1;
        end
        chk("t3 busy cycles", nb, 32);
        chk("t3 done cycle", done_at, 34);
        chk("t3 stall count", sc_done, 33);
        do_reset();
        nb = 0; done_at = 0; sc_done = 0;
        for (int c = 1; c <= 12; c++) begin
            clear_in();
            if (c <= 2) begin
                bus.id_mdu_start = 1;
                bus.ex_mem_read = c == 1; bus.ex_rd = 7; bus.id_rs1 = 7; bus.id_uses_rs1 = 1;
            end
            #1;
            if (c == 1) chk("t4 lu no busy next", bus.id_ex_flush, 1);
            if (bus.mdu_busy) nb++;
            if (bus.mdu_done && done_at == 0) begin
                done_at = c;
                sc_done = bus.stall_count;
            end
            step();
        end
        clear_in();
        chk("t4 busy cycles", nb, 4);
        chk("t4 done cycle", done_at, 7);
        chk("t4 stall count", sc_done, 6);
        bus.ex_branch_taken = 1; bus.id_mdu_start = 1;
        bus.ex_mem_read = 1; bus.ex_rd = 3; bus.id_rs1 = 3; bus.id_uses_rs1 = 1;
        #1;
        chk("t5 flushes", {bus.if_id_flush, bus.id_ex_flush}, 2'b11);
        chk("t5 pc_write", bus.pc_write, 1);
        step();
        clear_in();
        #1;
        chk("t5 stays idle", bus.mdu_busy, 0);
        do_reset();
        bus.id_mdu_start = 1; bus.id_mdu_is_div = 1;
        step();
        clear_in();
        for (int i = 0; i < 21; i++) step();
        #1;
        chk("t6 busy before rst", bus.mdu_busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("t6 busy cleared", bus.mdu_busy, 0);
        chk("t6 sc cleared", bus.stall_count, 0);
        chk("t6 running", bus.pc_write, 1);
        for (int i = 0; i < 3000; i++) begin
            step();
            rst = $urandom_range(63) == 0;
            bus.ex_branch_taken = $urandom_range(15) == 0;
            bus.ex_mem_read = 1'($urandom_range(1));
            bus.ex_rd = 5'($urandom_range(3));
            bus.id_rs1 = 5'($urandom_range(3));
            bus.id_rs2 = 5'($urandom_range(3));
            bus.id_uses_rs1 = 1'($urandom_range(1));
            bus.id_uses_rs2 = 1'($urandom_range(1));
            bus.id_mdu_start = $urandom_range(3) == 0;
            bus.id_mdu_is_div = $urandom_range(3) == 0;
        end
        do_reset();
        bus.ex_mem_read = 1; bus.ex_rd = 9; bus.id_rs1 = 9; bus.id_uses_rs1 = 1;
        for (int i = 0; i < 70000; i++) step();
        chk("sat count", bus.stall_count, 16'hFFFF);
        step();
        step();
        chk("sat holds", bus.stall_count, 16'hFFFF);
        clear_in();
        step();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
